// File: rtl/matrix_sampler.sv
// Nearest-neighbour decimation of the HDMI RGB stream down to the LED-matrix grid.
// Optional build macro MATRIX_SAMPLER_SERPENTINE_EN mirrors the column index on odd matrix rows.
module matrix_sampler #(
  parameter int MAX_WIDTH   = 1920,
  parameter int MAX_HEIGHT  = 1080,
  parameter int OUT_WIDTH   = 64,
  parameter int OUT_HEIGHT  = 32,
  parameter int COLOR_WIDTH = 8
) (
  input  logic                            I_rgb_clk,
  input  logic                            I_rst,
  input  logic                            I_rgb_de,
  input  logic [3*COLOR_WIDTH-1:0]        I_rgb_data,
  input  logic                            I_new_row,
  input  logic                            I_new_frame,
  input  logic [$clog2(MAX_WIDTH)-1:0]    I_image_width,
  input  logic                            I_width_valid,
  input  logic [$clog2(MAX_HEIGHT)-1:0]   I_image_height,
  input  logic                            I_height_valid,
  output logic                            O_pixel_valid,
  output logic [$clog2(OUT_WIDTH)-1:0]    O_pixel_x,
  output logic [$clog2(OUT_HEIGHT)-1:0]   O_pixel_y,
  output logic [3*COLOR_WIDTH-1:0]        O_pixel_data,
  output logic                            O_frame_done,
  output logic                            O_format_error
);

  localparam int WW = $clog2(MAX_WIDTH);
  localparam int HW = $clog2(MAX_HEIGHT);
  localparam int XW = $clog2(OUT_WIDTH);
  localparam int YW = $clog2(OUT_HEIGHT);
  localparam int DW = 3 * COLOR_WIDTH;

  localparam logic [WW:0] OW_X = (WW+1)'(OUT_WIDTH);
  localparam logic [HW:0] OH_Y = (HW+1)'(OUT_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   w_q, w_d;
  logic [HW-1:0]   h_q, h_d;
  logic [WW:0]     acc_x_q, acc_x_d;
  logic [HW:0]     acc_y_q, acc_y_d;
  logic [XW:0]     out_x_q, out_x_d;
  logic [YW-1:0]   out_y_q, out_y_d;
  logic            row_pending_q, row_pending_d;
  logic            row_sel_q, row_sel_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic [DW-1:0]   pix_data_q, pix_data_d;
  logic            frame_done_q, frame_done_d;
  logic            format_error_q, format_error_d;

  logic            geom_ok;
  logic [WW:0]     sum_x;
  logic [HW:0]     sum_y;
  logic            col_sel;
  logic            row_sel_v;
  logic            row_sel_now;
  logic            emit;
  logic            last_sample;
  logic [XW-1:0]   x_map;

  assign geom_ok = I_width_valid && I_height_valid &&
                   ({1'b0, I_image_width}  >= OW_X) &&
                   ({1'b0, I_image_height} >= OH_Y);

  // Accumulators stay below W (H) so adding the output size never overflows the extra bit.
  assign sum_x       = acc_x_q + OW_X;
  assign sum_y       = acc_y_q + OH_Y;
  assign col_sel     = (sum_x >= {1'b0, w_q});
  assign row_sel_v   = (sum_y >= {1'b0, h_q});
  assign row_sel_now = row_pending_q ? row_sel_v : row_sel_q;
  assign emit        = row_sel_now && col_sel && (out_x_q < (XW+1)'(OUT_WIDTH));
  assign last_sample = emit && (out_x_q == (XW+1)'(OUT_WIDTH - 1)) &&
                       (out_y_q == YW'(OUT_HEIGHT - 1));

`ifdef MATRIX_SAMPLER_SERPENTINE_EN
  assign x_map = out_y_q[0] ? (XW'(OUT_WIDTH - 1) - out_x_q[XW-1:0]) : out_x_q[XW-1:0];
`else
  assign x_map = out_x_q[XW-1:0];
`endif

  // O_pixel_valid is a one-cycle strobe with no backpressure; x/y/data are meaningful only while it is high.
  always_comb begin
    state_d        = state_q;
    w_d            = w_q;
    h_d            = h_q;
    acc_x_d        = acc_x_q;
    acc_y_d        = acc_y_q;
    out_x_d        = out_x_q;
    out_y_d        = out_y_q;
    row_pending_d  = row_pending_q;
    row_sel_d      = row_sel_q;
    pix_valid_d    = 1'b0;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    pix_data_d     = pix_data_q;
    frame_done_d   = 1'b0;
    format_error_d = format_error_q;

    if (I_new_frame) begin
      w_d            = I_image_width;
      h_d            = I_image_height;
      state_d        = geom_ok ? ST_ACTIVE : ST_IDLE;
      format_error_d = !geom_ok;
      acc_x_d        = '0;
      acc_y_d        = '0;
      out_x_d        = '0;
      out_y_d        = '0;
      row_pending_d  = 1'b1;
      row_sel_d      = 1'b0;
    end else if (state_q == ST_ACTIVE) begin
      if (I_new_row) begin
        acc_x_d       = '0;
        out_x_d       = '0;
        row_pending_d = 1'b1;
        row_sel_d     = 1'b0;
        if (row_sel_q) begin
          out_y_d = out_y_q + YW'(1);
        end
      end else if (I_rgb_de) begin
        if (row_pending_q) begin
          row_pending_d = 1'b0;
          row_sel_d     = row_sel_v;
          acc_y_d       = row_sel_v ? (sum_y - {1'b0, h_q}) : sum_y;
        end
        acc_x_d = col_sel ? (sum_x - {1'b0, w_q}) : sum_x;
        if (emit) begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_map;
          pix_y_d     = out_y_q;
          pix_data_d  = I_rgb_data;
          out_x_d     = out_x_q + (XW+1)'(1);
          if (last_sample) begin
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge I_rgb_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q        <= ST_IDLE;
      w_q            <= '0;
      h_q            <= '0;
      acc_x_q        <= '0;
      acc_y_q        <= '0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      row_pending_q  <= 1'b0;
      row_sel_q      <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      pix_data_q     <= '0;
      frame_done_q   <= 1'b0;
      format_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      h_q            <= h_d;
      acc_x_q        <= acc_x_d;
      acc_y_q        <= acc_y_d;
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
      row_pending_q  <= row_pending_d;
      row_sel_q      <= row_sel_d;
      pix_valid_q    <= pix_valid_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      pix_data_q     <= pix_data_d;
      frame_done_q   <= frame_done_d;
      format_error_q <= format_error_d;
    end
  end

  assign O_pixel_valid  = pix_valid_q;
  assign O_pixel_x      = pix_x_q;
  assign O_pixel_y      = pix_y_q;
  assign O_pixel_data   = pix_data_q;
  assign O_frame_done   = frame_done_q;
  assign O_format_error = format_error_q;

endmodule

// File: tb/tb_matrix_sampler.sv
// Directed bench for matrix_sampler: whole frames at several geometries against a
// wrap-count reference model, plus reset, format-error, abort, clipping and latency cases.
module tb_matrix_sampler;

  localparam int OW = 64;
  localparam int OH = 32;
  localparam int DW = 24;
  localparam int WW = 11;
  localparam int HW = 11;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int PW = YW + XW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rgb_de = 1'b0;
  logic [DW-1:0] rgb_data = '0;
  logic          new_row = 1'b0;
  logic          new_frame = 1'b0;
  logic [WW-1:0] image_width = '0;
  logic          width_valid = 1'b0;
  logic [HW-1:0] image_height = '0;
  logic          height_valid = 1'b0;
  logic          pix_valid;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [DW-1:0] pix_data;
  logic          frame_done;
  logic          format_error;

  always #5 clk = ~clk;

  matrix_sampler #(
    .MAX_WIDTH(1920), .MAX_HEIGHT(1080), .OUT_WIDTH(OW), .OUT_HEIGHT(OH), .COLOR_WIDTH(8)
  ) dut (
    .I_rgb_clk(clk), .I_rst(rst), .I_rgb_de(rgb_de), .I_rgb_data(rgb_data),
    .I_new_row(new_row), .I_new_frame(new_frame),
    .I_image_width(image_width), .I_width_valid(width_valid),
    .I_image_height(image_height), .I_height_valid(height_valid),
    .O_pixel_valid(pix_valid), .O_pixel_x(pix_x), .O_pixel_y(pix_y),
    .O_pixel_data(pix_data), .O_frame_done(frame_done), .O_format_error(format_error)
  );

  int            checks = 0;
  int            failures = 0;
  logic [PW-1:0] exp_q[$];
  bit            sb_on = 1'b0;
  bit            sb_ok = 1'b1;
  int            sample_cnt = 0;
  int            done_cnt = 0;
  int            done_bad = 0;
  logic [DW-1:0] first_data = '0;

  function automatic logic [DW-1:0] pix(int r, int c);
    return {8'(r), 8'(c), 8'(r * 3 + c)};
  endfunction

  // Scoreboard: stops comparing after the first mismatch of a test to keep the log short.
  always @(negedge clk) begin
    logic [PW-1:0] obs;
    logic [PW-1:0] exp;
    if (pix_valid) begin
      obs = {pix_y, pix_x, pix_data};
      if (sample_cnt == 0) first_data = pix_data;
      sample_cnt++;
      if (sb_on && sb_ok) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          sb_ok = 1'b0;
          $display("FAIL sb_unexpected got y=%0d x=%0d d=%h exp=none", pix_y, pix_x, pix_data);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            failures++;
            sb_ok = 1'b0;
            $display("FAIL sb_sample got y=%0d x=%0d d=%h exp y=%0d x=%0d d=%h",
                     pix_y, pix_x, pix_data, exp[PW-1 -: YW], exp[DW+XW-1 -: XW], exp[DW-1:0]);
          end
        end
      end
    end
    if (frame_done) begin
      done_cnt++;
      if (!pix_valid) done_bad++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    sb_ok      = 1'b1;
    sample_cnt = 0;
    done_cnt   = 0;
    done_bad   = 0;
  endtask

  task automatic pulse_frame(int w, int h, bit wv, bit hv);
    image_width  = WW'(w);
    image_height = HW'(h);
    width_valid  = wv;
    height_valid = hv;
    new_frame    = 1'b1;
    step();
    new_frame = 1'b0;
    step();
  endtask

  task automatic drive_row(int r, int n_de);
    new_row = 1'b1;
    step();
    new_row = 1'b0;
    step();
    for (int c = 0; c < n_de; c++) begin
      rgb_de   = 1'b1;
      rgb_data = pix(r, c);
      step();
    end
    rgb_de   = 1'b0;
    rgb_data = '0;
    step();
    step();
  endtask

  task automatic run_frame(int w, int h, int rows, int n_de);
    pulse_frame(w, h, 1'b1, 1'b1);
    for (int r = 0; r < rows; r++) drive_row(r, n_de);
    repeat (3) step();
  endtask

  // Reference: a source line is taken when floor((i+1)*N/S) > floor(i*N/S).
  task automatic gen_exp(int w, int h, int rows, int n_de);
    int y, x, xo;
    for (int r = 0; r < rows; r++) begin
      if ((r + 1) * OH / h > r * OH / h) begin
        y = (r + 1) * OH / h - 1;
        for (int c = 0; c < n_de; c++) begin
          if ((c + 1) * OW / w > c * OW / w) begin
            x = (c + 1) * OW / w - 1;
            if (x < OW) begin
              xo = x;
`ifdef MATRIX_SAMPLER_SERPENTINE_EN
              if (y % 2 == 1) xo = OW - 1 - x;
`endif
              exp_q.push_back({YW'(y), XW'(xo), pix(r, c)});
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pix_valid); end
    checks++; if (pix_x !== '0) begin failures++; $display("FAIL reset_x got=%0d exp=0", pix_x); end
    checks++; if (pix_y !== '0) begin failures++; $display("FAIL reset_y got=%0d exp=0", pix_y); end
    checks++; if (pix_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", pix_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (format_error !== 1'b0) begin failures++; $display("FAIL reset_fmt got=%b exp=0", format_error); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_timing();
    sb_on = 1'b0;
    clear_sb();
    image_width = WW'(32); image_height = HW'(32); width_valid = 1'b1; height_valid = 1'b1;
    new_frame = 1'b1;
    checks++; if (format_error !== 1'b0) begin failures++; $display("FAIL fmt_before_edge got=%b exp=0", format_error); end
    step();
    new_frame = 1'b0;
    checks++; if (format_error !== 1'b1) begin failures++; $display("FAIL fmt_narrow got=%b exp=1", format_error); end
    pulse_frame(64, 32, 1'b1, 1'b0);
    checks++; if (format_error !== 1'b1) begin failures++; $display("FAIL fmt_hvalid_low got=%b exp=1", format_error); end
    pulse_frame(64, 32, 1'b1, 1'b1);
    checks++; if (format_error !== 1'b0) begin failures++; $display("FAIL fmt_clear got=%b exp=0", format_error); end
    new_row = 1'b1;
    step();
    new_row  = 1'b0;
    rgb_de   = 1'b1;
    rgb_data = 24'hA5C3E7;
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL lat_pre got=%b exp=0", pix_valid); end
    step();
    rgb_de = 1'b0;
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", pix_valid); end
    checks++; if ({pix_y, pix_x} !== 11'd0) begin failures++; $display("FAIL lat_xy got=%0d,%0d exp=0,0", pix_x, pix_y); end
    checks++; if (pix_data !== 24'hA5C3E7) begin failures++; $display("FAIL lat_data got=%h exp=a5c3e7", pix_data); end
    step();
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL lat_drop got=%b exp=0", pix_valid); end
  endtask

  task automatic test_full_rate();
    clear_sb();
    sb_on = 1'b1;
    gen_exp(64, 32, 32, 64);
    run_frame(64, 32, 32, 64);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_left got=%0d exp=0", exp_q.size()); end
    checks++; if (sample_cnt != 2048) begin failures++; $display("FAIL full_count got=%0d exp=2048", sample_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    checks++; if (done_bad != 0) begin failures++; $display("FAIL full_done_align got=%0d exp=0", done_bad); end
  endtask

  task automatic test_decimate(int w, int h);
    clear_sb();
    sb_on = 1'b1;
    gen_exp(w, h, h, w);
    run_frame(w, h, h, w);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL dec%0d_left got=%0d exp=0", w, exp_q.size()); end
    checks++; if (sample_cnt != 2048) begin failures++; $display("FAIL dec%0d_count got=%0d exp=2048", w, sample_cnt); end
    checks++; if (first_data !== pix(1, 1)) begin failures++; $display("FAIL dec%0d_first got=%h exp=%h", w, first_data, pix(1, 1)); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL dec%0d_done got=%0d exp=1", w, done_cnt); end
  endtask

  task automatic test_format_error();
    clear_sb();
    sb_on = 1'b1;
    run_frame(32, 32, 32, 32);
    checks++; if (format_error !== 1'b1) begin failures++; $display("FAIL fmt_err got=%b exp=1", format_error); end
    checks++; if (sample_cnt != 0) begin failures++; $display("FAIL fmt_samples got=%0d exp=0", sample_cnt); end
    gen_exp(64, 32, 32, 64);
    run_frame(64, 32, 32, 64);
    checks++; if (format_error !== 1'b0) begin failures++; $display("FAIL fmt_recover got=%b exp=0", format_error); end
    checks++; if (sample_cnt != 2048) begin failures++; $display("FAIL fmt_count got=%0d exp=2048", sample_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL fmt_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_sb();
    sb_on = 1'b0;
    pulse_frame(64, 32, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++) drive_row(r, 64);
    new_row = 1'b1;
    step();
    new_row = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rgb_de   = 1'b1;
      rgb_data = pix(5, c);
      step();
    end
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", pix_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", pix_valid); end
    checks++; if ({pix_y, pix_x} !== 11'd0) begin failures++; $display("FAIL rstmid_xy got=%0d,%0d exp=0,0", pix_x, pix_y); end
    checks++; if (pix_data !== '0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", pix_data); end
    rgb_de = 1'b0;
    rgb_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    sample_cnt = 0;
    for (int r = 0; r < 3; r++) drive_row(r, 64);
    checks++; if (sample_cnt != 0) begin failures++; $display("FAIL rstmid_silent got=%0d exp=0", sample_cnt); end
    clear_sb();
    sb_on = 1'b1;
    gen_exp(64, 32, 32, 64);
    run_frame(64, 32, 32, 64);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_left got=%0d exp=0", exp_q.size()); end
    checks++; if (sample_cnt != 2048) begin failures++; $display("FAIL rstmid_count got=%0d exp=2048", sample_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_abort_frame();
    clear_sb();
    sb_on = 1'b1;
    gen_exp(64, 32, 10, 64);
    gen_exp(64, 32, 32, 64);
    run_frame(64, 32, 10, 64);
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_early_done got=%0d exp=0", done_cnt); end
    run_frame(64, 32, 32, 64);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL abort_left got=%0d exp=0", exp_q.size()); end
    checks++; if (sample_cnt != 2688) begin failures++; $display("FAIL abort_count got=%0d exp=2688", sample_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_clip();
    clear_sb();
    sb_on = 1'b1;
    gen_exp(64, 32, 32, 70);
    run_frame(64, 32, 32, 70);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL clip_left got=%0d exp=0", exp_q.size()); end
    checks++; if (sample_cnt != 2048) begin failures++; $display("FAIL clip_count got=%0d exp=2048", sample_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL clip_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_full_rate();
    test_decimate(128, 64);
    test_decimate(96, 48);
    test_format_error();
    test_reset_mid_frame();
    test_abort_frame();
    test_clip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
